// File: rtl/cal_pkg.sv
// Shared calendar encodings and the month-length table used by the date counter.
package cal_pkg;

    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;
    localparam logic [MONTH_W-1:0] MONTH_DEC = MONTH_W'(12);

    typedef enum logic [1:0] {
        SEL_DAY   = 2'd0,
        SEL_MONTH = 2'd1,
        SEL_YEAR  = 2'd2,
        SEL_NONE  = 2'd3
    } sel_e;

    // Month length; out-of-range months fall to 31 and are never reached in practice.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic               leap);
        logic [DAY_W-1:0] dim;
        case (month)
            MONTH_W'(2):                           dim = leap ? DAY_W'(29) : DAY_W'(28);
            MONTH_W'(4), MONTH_W'(6),
            MONTH_W'(9), MONTH_W'(11):             dim = DAY_W'(30);
            default:                               dim = DAY_W'(31);
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/dim_lut.sv
// Days-in-month lookup for a given month and leap flag.
module dim_lut
    import cal_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   dim
);

    assign dim = days_in_month(month, leap);

endmodule

// File: rtl/date_counter.sv
// Day/month/year calendar counter with validated parallel loads and a gated field databus.
module date_counter
    import cal_pkg::*;
#(
    parameter int unsigned YEAR_W   = 7,
    parameter int unsigned YEAR_MAX = 99,
    parameter int unsigned BUS_W    = 8
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              tick,
    input  logic              load,
    input  logic [1:0]        load_sel,
    input  logic [BUS_W-1:0]  load_data,
    input  logic              enable,
    input  logic [1:0]        bus_sel,
    output logic [DAY_W-1:0]  day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0] year,
    output logic [BUS_W-1:0]  databus,
    output logic              year_carry,
    output logic              load_err
);

    localparam logic [YEAR_W-1:0] YEAR_LAST = YEAR_W'(YEAR_MAX);

    logic [DAY_W-1:0]   dim_cur;
    logic [DAY_W-1:0]   dim_cand;
    logic [MONTH_W-1:0] cand_month;
    logic [YEAR_W-1:0]  cand_year;
    logic [DAY_W-1:0]   ld_day;
    logic [MONTH_W-1:0] ld_month;
    logic [YEAR_W-1:0]  ld_year;
    logic               day_ok;
    logic               month_ok;
    logic               year_ok;

    logic [DAY_W-1:0]   day_n;
    logic [MONTH_W-1:0] month_n;
    logic [YEAR_W-1:0]  year_n;
    logic               carry_n;
    logic               err_n;

    assign ld_day   = load_data[DAY_W-1:0];
    assign ld_month = load_data[MONTH_W-1:0];
    assign ld_year  = load_data[YEAR_W-1:0];

    // Candidate calendar after a month/year load, used to clamp the day.
    assign cand_month = (sel_e'(load_sel) == SEL_MONTH) ? ld_month : month;
    assign cand_year  = (sel_e'(load_sel) == SEL_YEAR)  ? ld_year  : year;

    dim_lut u_dim_cur (
        .month (month),
        .leap  (year[1:0] == 2'b00),
        .dim   (dim_cur)
    );

    dim_lut u_dim_cand (
        .month (cand_month),
        .leap  (cand_year[1:0] == 2'b00),
        .dim   (dim_cand)
    );

    // Load checks: no stray high bits, and value in the field's legal range.
    assign day_ok   = ((load_data >> DAY_W) == '0) && (ld_day != '0) && (ld_day <= dim_cur);
    assign month_ok = ((load_data >> MONTH_W) == '0) && (ld_month != '0)
                      && (ld_month <= MONTH_DEC);
    assign year_ok  = ((load_data >> YEAR_W) == '0) && (ld_year <= YEAR_LAST);

    always_comb begin
        day_n   = day;
        month_n = month;
        year_n  = year;
        carry_n = 1'b0;
        err_n   = 1'b0;
        if (load) begin
            case (sel_e'(load_sel))
                SEL_DAY: begin
                    if (day_ok) day_n = ld_day;
                    else        err_n = 1'b1;
                end
                SEL_MONTH: begin
                    if (month_ok) begin
                        month_n = ld_month;
                        if (day > dim_cand) day_n = dim_cand;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                SEL_YEAR: begin
                    if (year_ok) begin
                        year_n = ld_year;
                        if (day > dim_cand) day_n = dim_cand;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (tick) begin
            if (day == dim_cur) begin
                day_n = DAY_W'(1);
                if (month == MONTH_DEC) begin
                    month_n = MONTH_W'(1);
                    if (year == YEAR_LAST) begin
                        year_n  = '0;
                        carry_n = 1'b1;
                    end else begin
                        year_n = year + YEAR_W'(1);
                    end
                end else begin
                    month_n = month + MONTH_W'(1);
                end
            end else begin
                day_n = day + DAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            day        <= DAY_W'(1);
            month      <= MONTH_W'(1);
            year       <= '0;
            year_carry <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            day        <= day_n;
            month      <= month_n;
            year       <= year_n;
            year_carry <= carry_n;
            load_err   <= err_n;
        end
    end

    always_comb begin
        databus = '0;
        if (enable) begin
            case (sel_e'(bus_sel))
                SEL_DAY:   databus = BUS_W'(day);
                SEL_MONTH: databus = BUS_W'(month);
                SEL_YEAR:  databus = BUS_W'(year);
                default:   databus = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_date_counter.sv
// Directed self-checking bench for date_counter with hand-computed expected dates.
module tb_date_counter;

    logic       clk;
    logic       clear_n;
    logic       tick;
    logic       load;
    logic [1:0] load_sel;
    logic [7:0] load_data;
    logic       enable;
    logic [1:0] bus_sel;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [7:0] databus;
    logic       year_carry;
    logic       load_err;

    int n_cmp = 0;
    int n_bad = 0;

    date_counter #(.YEAR_W(7), .YEAR_MAX(99), .BUS_W(8)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .tick       (tick),
        .load       (load),
        .load_sel   (load_sel),
        .load_data  (load_data),
        .enable     (enable),
        .bus_sel    (bus_sel),
        .day        (day),
        .month      (month),
        .year       (year),
        .databus    (databus),
        .year_carry (year_carry),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [7:0] data);
        load = 1'b1; load_sel = sel; load_data = data;
        step();
        load = 1'b0; load_sel = 2'd3; load_data = 8'h00;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        n_cmp++;
        if ({day, month, year} !== {5'd1, 4'd1, 7'd0}) begin
            n_bad++; $display("FAIL reset_date got %0d/%0d/%0d want 1/1/0", day, month, year);
        end
        n_cmp++;
        if ({year_carry, load_err} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags got carry=%b err=%b want 0 0", year_carry, load_err);
        end
        enable = 1'b1; bus_sel = 2'd1;
        #1;
        n_cmp++;
        if (databus !== 8'h01) begin
            n_bad++; $display("FAIL reset_bus got %h want 01", databus);
        end
    endtask

    task automatic test_tick_rollover();
        do_load(2'd0, 8'd31);
        do_tick();
        n_cmp++;
        if ({day, month, year} !== {5'd1, 4'd2, 7'd0}) begin
            n_bad++; $display("FAIL tick_jan31 got %0d/%0d/%0d want 1/2/0", day, month, year);
        end
        do_load(2'd2, 8'd23); do_load(2'd1, 8'd2); do_load(2'd0, 8'd28);
        do_tick();
        n_cmp++;
        if ({day, month, year} !== {5'd1, 4'd3, 7'd23}) begin
            n_bad++; $display("FAIL tick_feb28_23 got %0d/%0d/%0d want 1/3/23", day, month, year);
        end
        do_load(2'd2, 8'd24); do_load(2'd1, 8'd2); do_load(2'd0, 8'd28);
        do_tick();
        n_cmp++;
        if ({day, month, year} !== {5'd29, 4'd2, 7'd24}) begin
            n_bad++; $display("FAIL tick_feb28_24 got %0d/%0d/%0d want 29/2/24", day, month, year);
        end
        do_tick();
        n_cmp++;
        if ({day, month, year} !== {5'd1, 4'd3, 7'd24}) begin
            n_bad++; $display("FAIL tick_feb29_24 got %0d/%0d/%0d want 1/3/24", day, month, year);
        end
        do_load(2'd1, 8'd4); do_load(2'd0, 8'd30);
        do_tick();
        n_cmp++;
        if ({day, month, year} !== {5'd1, 4'd5, 7'd24}) begin
            n_bad++; $display("FAIL tick_apr30 got %0d/%0d/%0d want 1/5/24", day, month, year);
        end
    endtask

    task automatic test_year_wrap();
        do_load(2'd2, 8'd99); do_load(2'd1, 8'd12); do_load(2'd0, 8'd31);
        n_cmp++;
        if (year_carry !== 1'b0) begin
            n_bad++; $display("FAIL carry_idle got %b want 0", year_carry);
        end
        do_tick();
        n_cmp++;
        if ({day, month, year, year_carry} !== {5'd1, 4'd1, 7'd0, 1'b1}) begin
            n_bad++; $display("FAIL year_wrap got %0d/%0d/%0d c=%b want 1/1/0 c=1",
                              day, month, year, year_carry);
        end
        step();
        n_cmp++;
        if (year_carry !== 1'b0) begin
            n_bad++; $display("FAIL carry_pulse got %b want 0", year_carry);
        end
        do_load(2'd2, 8'd50); do_load(2'd1, 8'd12); do_load(2'd0, 8'd31);
        do_tick();
        n_cmp++;
        if ({day, month, year, year_carry} !== {5'd1, 4'd1, 7'd51, 1'b0}) begin
            n_bad++; $display("FAIL year_inc got %0d/%0d/%0d c=%b want 1/1/51 c=0",
                              day, month, year, year_carry);
        end
    endtask

    task automatic test_load_validation();
        do_load(2'd1, 8'd13);
        n_cmp++;
        if ({load_err, day, month, year} !== {1'b1, 5'd1, 4'd1, 7'd51}) begin
            n_bad++; $display("FAIL load_month13 got err=%b %0d/%0d/%0d want err=1 1/1/51",
                              load_err, day, month, year);
        end
        step();
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_bad++; $display("FAIL err_pulse got %b want 0", load_err);
        end
        do_load(2'd1, 8'd4);
        do_load(2'd0, 8'd31);
        n_cmp++;
        if ({load_err, day, month} !== {1'b1, 5'd1, 4'd4}) begin
            n_bad++; $display("FAIL load_day31_apr got err=%b %0d/%0d want err=1 1/4",
                              load_err, day, month);
        end
        do_load(2'd0, 8'd0);
        n_cmp++;
        if ({load_err, day} !== {1'b1, 5'd1}) begin
            n_bad++; $display("FAIL load_day0 got err=%b day=%0d want err=1 day=1", load_err, day);
        end
        do_load(2'd0, 8'h21);
        n_cmp++;
        if ({load_err, day} !== {1'b1, 5'd1}) begin
            n_bad++; $display("FAIL load_day_hibits got err=%b day=%0d want err=1 day=1", load_err, day);
        end
        do_load(2'd2, 8'd100);
        n_cmp++;
        if ({load_err, year} !== {1'b1, 7'd51}) begin
            n_bad++; $display("FAIL load_year100 got err=%b year=%0d want err=1 51", load_err, year);
        end
        do_load(2'd1, 8'd1); do_load(2'd0, 8'd31); do_load(2'd2, 8'd23);
        do_load(2'd1, 8'd2);
        n_cmp++;
        if ({load_err, day, month, year} !== {1'b0, 5'd28, 4'd2, 7'd23}) begin
            n_bad++; $display("FAIL clamp_feb got err=%b %0d/%0d/%0d want err=0 28/2/23",
                              load_err, day, month, year);
        end
        do_load(2'd1, 8'd3); do_load(2'd0, 8'd29);
        do_load(2'd1, 8'd2); do_load(2'd0, 8'd29); do_load(2'd2, 8'd24);
        do_load(2'd2, 8'd25);
        n_cmp++;
        if ({load_err, day, month, year} !== {1'b0, 5'd28, 4'd2, 7'd25}) begin
            n_bad++; $display("FAIL clamp_year got err=%b %0d/%0d/%0d want err=0 28/2/25",
                              load_err, day, month, year);
        end
    endtask

    task automatic test_load_tick_priority();
        do_load(2'd2, 8'd30); do_load(2'd1, 8'd5); do_load(2'd0, 8'd10);
        tick = 1'b1;
        do_load(2'd0, 8'd20);
        tick = 1'b0;
        n_cmp++;
        if ({load_err, day, month, year} !== {1'b0, 5'd20, 4'd5, 7'd30}) begin
            n_bad++; $display("FAIL load_over_tick got err=%b %0d/%0d/%0d want err=0 20/5/30",
                              load_err, day, month, year);
        end
        tick = 1'b1;
        do_load(2'd3, 8'd7);
        tick = 1'b0;
        n_cmp++;
        if ({load_err, day, month, year} !== {1'b0, 5'd20, 4'd5, 7'd30}) begin
            n_bad++; $display("FAIL load_none_tick got err=%b %0d/%0d/%0d want err=0 20/5/30",
                              load_err, day, month, year);
        end
    endtask

    task automatic test_bus_and_midreset();
        logic [7:0] exp_bus [4];
        exp_bus[0] = 8'd20; exp_bus[1] = 8'd5; exp_bus[2] = 8'd30; exp_bus[3] = 8'd0;
        for (int s = 0; s < 4; s++) begin
            enable = 1'b0; bus_sel = 2'(s);
            #1;
            n_cmp++;
            if (databus !== 8'h00) begin
                n_bad++; $display("FAIL bus_disabled sel=%0d got %h want 00", s, databus);
            end
            enable = 1'b1;
            #1;
            n_cmp++;
            if (databus !== exp_bus[s]) begin
                n_bad++; $display("FAIL bus_sel%0d got %h want %h", s, databus, exp_bus[s]);
            end
        end
        tick = 1'b1;
        step(); step(); step();
        n_cmp++;
        if ({day, month, year} !== {5'd23, 4'd5, 7'd30}) begin
            n_bad++; $display("FAIL tick_stream got %0d/%0d/%0d want 23/5/30", day, month, year);
        end
        clear_n = 1'b0;
        load = 1'b1; load_sel = 2'd1; load_data = 8'd13;
        step();
        clear_n = 1'b1; tick = 1'b0;
        load = 1'b0; load_sel = 2'd3; load_data = 8'h00;
        n_cmp++;
        if ({day, month, year, year_carry, load_err} !== {5'd1, 4'd1, 7'd0, 2'b00}) begin
            n_bad++; $display("FAIL midreset got %0d/%0d/%0d c=%b e=%b want 1/1/0 c=0 e=0",
                              day, month, year, year_carry, load_err);
        end
    endtask

    initial begin
        clear_n = 1'b1; tick = 1'b0; load = 1'b0; load_sel = 2'd3;
        load_data = 8'h00; enable = 1'b0; bus_sel = 2'd0;
        #2;
        test_reset();
        test_tick_rollover();
        test_year_wrap();
        test_load_validation();
        test_load_tick_priority();
        test_bus_and_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
